cam_engine: RTL and testbench
=============================

# cam_engine

Parametrised, command-driven content-addressable parallel processor core. It extends the earlier compare/cells/tags CAM with the following:
- a registered command/response handshake;
- cumulative (AND) search;
- masked multi-write to all tagged cells;
- wired-OR read;
- a first-match index and tag population count.

It sits between the host sequencer and the CAM storage array, replacing direct strobe-driven control.

## Interface
Parameters:
- NUM_BITS, 32, word width of each cell
- NUM_CELLS, 64, number of cells; must be ≥2
- IDX_W, $clog2(NUM_CELLS), width of a cell index
- CNT_W, $clog2(NUM_CELLS+1), width of the tag count

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  3  opcode: 0 NOP, 1 SEARCH, 2 SEARCH_AND, 3 SET_ALL, 4 SELECT_FIRST, 5 WRITE, 6 READ, 7 reserved
- comparand  in  NUM_BITS  search key
- mask  in  NUM_BITS  search bit enable (1 = compare bit)
- wdata  in  NUM_BITS  write data
- wmask  in  NUM_BITS  write bit enable (1 = overwrite bit)
- rsp_valid  out  1  one-cycle response strobe
- rsp_err  out  1  reserved opcode received
- rsp_some  out  1  at least one tag set
- rsp_index  out  IDX_W  lowest set tag index; 0 when none
- rsp_count  out  CNT_W  number of set tags
- read_data  out  NUM_BITS  bitwise OR of all tagged cells (READ only; else holds)
- tag_wires  out  NUM_CELLS  current tag register

## Operation
- Operands (op, comparand, mask, wdata, wmask) are registered on handshake (cmd_valid & cmd_ready).
- match[i] = &(~(cell[i] ^ comparand) | ~mask). mask = 0 matches every cell.
- SEARCH: tags ← match.
- SEARCH_AND: tags ← tags & match.
- SET_ALL: tags ← all ones.
- SELECT_FIRST: tags ← only the lowest set bit; if none set, tags stay all zero.
- WRITE: for each i with tags[i], cell[i] ← (cell[i] & ~wmask) | (wdata & wmask). Tags are unchanged. With no tags set, nothing is written.
- READ: read_data ← OR over tagged cells; 0 if none. Tags are unchanged.
- NOP: no state change; a response is still issued.
- Reserved opcode 7: treated as NOP and rsp_err = 1.
- Response status (some/index/count) always reflects the tag register after the command executes.

FSM states:
- IDLE: cmd_ready = 1. On handshake → EXEC.
- EXEC: the operation commits at the end of the cycle. → RESP.
- RESP: rsp_valid = 1 and all rsp_* fields are valid. → IDLE.

## Timing
- Handshake at edge t0; commit at t1; rsp_valid high for the cycle t1–t2; cmd_ready high again from t2.
- Throughput is one command per 3 cycles. cmd_ready is low in EXEC and RESP; cmd_valid is ignored there and input changes have no effect.
- rsp_* are registered outputs. They hold their values outside RESP, and rsp_valid is 0 outside RESP.
- tag_wires updates at the commit edge t1.
- Reset values: state IDLE, cmd_ready 1, all cells 0, tags 0, rsp_valid 0, rsp_err 0, rsp_some 0, rsp_index 0, rsp_count 0, read_data 0.
- Reset mid-operation (RST high at any edge): returns to IDLE. An in-flight command does not commit, and no response is issued.
- RST and cmd_valid asserted together: reset wins and the command is not accepted.
- Priority: the lowest index wins in SELECT_FIRST and rsp_index. With NUM_CELLS tags set, rsp_count = NUM_CELLS, with no overflow because CNT_W covers it.

## Structure
- Shared package cam_pkg: opcode enum cam_op_e, CAM_OP_W = 3, and the state enum.
- Sub-module cam_prio_enc (parameter NUM_CELLS): combinational. Takes tags and outputs the one-hot first bit, index and some flag. It is used both by SELECT_FIRST and by response generation.
- Popcount and the OR-reduce read are inline in cam_engine.

## Test plan
- Reset, then SET_ALL → rsp_some = 1, rsp_index = 0, rsp_count = NUM_CELLS, tag_wires all ones; rsp_valid exactly 2 cycles after the handshake edge.
- SET_ALL; WRITE wdata = 0xA5, wmask = 0xFF; SEARCH comparand = 0xA5, mask = 0xFF → count = NUM_CELLS. Then SEARCH comparand = 0x5A → rsp_some = 0, rsp_index = 0, count 0.
- Load cells 3 and 7 with 0x10 (via SELECT_FIRST-narrowed writes), others 0.
  - SEARCH 0x10 → index 3, count 2.
  - SELECT_FIRST → tag_wires has only bit 3 set.
  - WRITE wdata = 0x01, wmask = 0x01 → cell 3 = 0x11.
  - SEARCH_AND 0x11 → count 1, index 3.
- Tags on cells holding 0x0F and 0xF0; READ → read_data = 0xFF. Tags cleared, then READ → read_data = 0.
- cmd_op = 7 → rsp_err = 1 and tags unchanged. cmd_valid held high through EXEC/RESP → only one command accepted per 3 cycles.
- Accept WRITE, then assert RST in EXEC → no cell changes, no rsp_valid, all outputs at reset values, cmd_ready = 1 the cycle after reset deasserts.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the CAM engine: opcodes, the width of the opcode
// field, and the encoding of the control state machine.
package cam_pkg;

   localparam int CAM_OP_W = 3;

   // Command opcodes as seen on cmd_op. Opcode 7 is kept reserved so the
   // host can be told about a bad command instead of having it silently
   // reinterpreted.
   typedef enum logic [CAM_OP_W-1:0] {
      OP_NOP          = 3'd0,
      OP_SEARCH       = 3'd1,
      OP_SEARCH_AND   = 3'd2,
      OP_SET_ALL      = 3'd3,
      OP_SELECT_FIRST = 3'd4,
      OP_WRITE        = 3'd5,
      OP_READ         = 3'd6,
      OP_RESERVED     = 3'd7
   } cam_op_e;

   // Control states. Every command takes one IDLE (accept), one EXEC
   // (commit) and one RESP (report) cycle.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } cam_state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index-wins priority encoder over the tag vector. It gives the
// isolated lowest set bit (used to narrow tags for SELECT_FIRST), the index
// of that bit, and whether any bit is set at all.
module cam_prio_enc
   import cam_pkg::*;
#(
   parameter int NUM_CELLS = 64,
   parameter int IDX_W     = $clog2(NUM_CELLS)
) (
   input  logic [NUM_CELLS-1:0] tags,
   output logic [NUM_CELLS-1:0] firstOneHot,
   output logic [IDX_W-1:0]     firstIndex,
   output logic                 anySet
);

   // The two's-complement trick tags & -tags isolates the lowest set bit in
   // one adder, which keeps the one-hot path short. The index is found with
   // a downward scan so the last assignment made is the lowest set bit; an
   // empty tag vector leaves the index at zero.
   always_comb begin
      firstOneHot = tags & (~tags + NUM_CELLS'(1));
      anySet      = |tags;
      firstIndex  = '0;
      for (int i = NUM_CELLS - 1; i >= 0; i--) begin
         if (tags[i]) begin
            firstIndex = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/cam_engine.sv
// Command-driven content-addressable parallel processor core. A host
// hands over one command at a time through a valid/ready handshake; the
// engine searches, narrows, writes or reads all tagged cells in parallel and
// answers with a one-cycle response carrying the resulting tag status.
module cam_engine
   import cam_pkg::*;
#(
   parameter int NUM_BITS  = 32,
   parameter int NUM_CELLS = 64,
   parameter int IDX_W     = $clog2(NUM_CELLS),
   parameter int CNT_W     = $clog2(NUM_CELLS + 1)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [CAM_OP_W-1:0]  cmd_op,
   input  logic [NUM_BITS-1:0]  comparand,
   input  logic [NUM_BITS-1:0]  mask,
   input  logic [NUM_BITS-1:0]  wdata,
   input  logic [NUM_BITS-1:0]  wmask,
   output logic                 rsp_valid,
   output logic                 rsp_err,
   output logic                 rsp_some,
   output logic [IDX_W-1:0]     rsp_index,
   output logic [CNT_W-1:0]     rsp_count,
   output logic [NUM_BITS-1:0]  read_data,
   output logic [NUM_CELLS-1:0] tag_wires
);

   cam_state_e stateQ;
   cam_state_e stateD;

   cam_op_e             opQ;
   logic [NUM_BITS-1:0] comparandQ;
   logic [NUM_BITS-1:0] maskQ;
   logic [NUM_BITS-1:0] wdataQ;
   logic [NUM_BITS-1:0] wmaskQ;

   logic [NUM_BITS-1:0]  cellsQ [NUM_CELLS];
   logic [NUM_CELLS-1:0] tagsQ;
   logic [NUM_CELLS-1:0] tagsD;
   logic [NUM_CELLS-1:0] tagsPre;
   logic [NUM_CELLS-1:0] matchVec;
   logic [NUM_CELLS-1:0] encIn;
   logic [NUM_CELLS-1:0] firstOneHot;
   logic [IDX_W-1:0]     encIndex;
   logic                 encSome;
   logic [CNT_W-1:0]     countD;
   logic [NUM_BITS-1:0]  orData;

   logic                 rspErrQ;
   logic                 rspSomeQ;
   logic [IDX_W-1:0]     rspIndexQ;
   logic [CNT_W-1:0]     rspCountQ;
   logic [NUM_BITS-1:0]  readDataQ;

   logic                 handshake;

   assign cmd_ready = (stateQ == ST_IDLE);
   assign handshake = cmd_valid & cmd_ready;
   assign rsp_valid = (stateQ == ST_RESP);
   assign rsp_err   = rspErrQ;
   assign rsp_some  = rspSomeQ;
   assign rsp_index = rspIndexQ;
   assign rsp_count = rspCountQ;
   assign read_data = readDataQ;
   assign tag_wires = tagsQ;

   // Control state register. Reset is synchronous and always wins, so a
   // command presented in the same cycle as reset is never accepted and an
   // in-flight command is simply dropped.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stateQ <= ST_IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   // Fixed three-cycle walk per command: accept in IDLE, commit in EXEC,
   // report in RESP. cmd_valid only matters in IDLE, which is what limits
   // throughput to one command every three cycles.
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         ST_IDLE: begin
            if (cmd_valid) begin
               stateD = ST_EXEC;
            end
         end
         ST_EXEC: stateD = ST_RESP;
         ST_RESP: stateD = ST_IDLE;
         default: stateD = ST_IDLE;
      endcase
   end

   // Operands are captured on the handshake so the host is free to change
   // the inputs while the command is executing.
   always_ff @(posedge CLK) begin
      if (RST) begin
         opQ        <= OP_NOP;
         comparandQ <= '0;
         maskQ      <= '0;
         wdataQ     <= '0;
         wmaskQ     <= '0;
      end else if (handshake) begin
         opQ        <= cam_op_e'(cmd_op);
         comparandQ <= comparand;
         maskQ      <= mask;
         wdataQ     <= wdata;
         wmaskQ     <= wmask;
      end
   end

   // Per-cell match: every enabled bit must agree with the comparand, and
   // disabled bits are forced true, so an all-zero mask matches every cell.
   always_comb begin
      matchVec = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         matchVec[i] = &(~(cellsQ[i] ^ comparandQ) | ~maskQ);
      end
   end

   // New tag value for every opcode that does not need the priority
   // encoder. Keeping SELECT_FIRST out of this block lets the single encoder
   // instance serve both narrowing and response generation without forming
   // a combinational loop.
   always_comb begin
      tagsPre = tagsQ;
      case (opQ)
         OP_SEARCH:     tagsPre = matchVec;
         OP_SEARCH_AND: tagsPre = tagsQ & matchVec;
         OP_SET_ALL:    tagsPre = '1;
         default:       tagsPre = tagsQ;
      endcase
   end

   // For SELECT_FIRST the encoder looks at the old tags; its first index and
   // some flag are then exactly those of the narrowed result. For all other
   // opcodes it looks at the new tags directly.
   assign encIn = (opQ == OP_SELECT_FIRST) ? tagsQ : tagsPre;

   cam_prio_enc #(
      .NUM_CELLS (NUM_CELLS),
      .IDX_W     (IDX_W)
   ) u_prio_enc (
      .tags        (encIn),
      .firstOneHot (firstOneHot),
      .firstIndex  (encIndex),
      .anySet      (encSome)
   );

   // Tags only change in the commit cycle; everywhere else they hold.
   always_comb begin
      tagsD = tagsQ;
      if (stateQ == ST_EXEC) begin
         if (opQ == OP_SELECT_FIRST) begin
            tagsD = firstOneHot;
         end else begin
            tagsD = tagsPre;
         end
      end
   end

   // Population count of the post-command tags, so the response reports the
   // state the command leaves behind. CNT_W is wide enough for all cells set.
   always_comb begin
      countD = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         countD = countD + CNT_W'(tagsD[i]);
      end
   end

   // Wired-OR read across every tagged cell; with nothing tagged this
   // naturally yields zero.
   always_comb begin
      orData = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (tagsQ[i]) begin
            orData = orData | cellsQ[i];
         end
      end
   end

   // Tag register, updated at the commit edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         tagsQ <= '0;
      end else begin
         tagsQ <= tagsD;
      end
   end

   // Masked multi-write: every tagged cell takes wdata on the bits selected
   // by wmask and keeps its own value elsewhere. Untagged cells never change.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            cellsQ[i] <= '0;
         end
      end else if ((stateQ == ST_EXEC) && (opQ == OP_WRITE)) begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            if (tagsQ[i]) begin
               cellsQ[i] <= (cellsQ[i] & ~wmaskQ) | (wdataQ & wmaskQ);
            end
         end
      end
   end

   // Response fields are loaded at the commit edge so they are already
   // valid during RESP, and hold until the next commit. read_data is only
   // refreshed by READ so the host can pick it up later.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rspErrQ   <= 1'b0;
         rspSomeQ  <= 1'b0;
         rspIndexQ <= '0;
         rspCountQ <= '0;
         readDataQ <= '0;
      end else if (stateQ == ST_EXEC) begin
         rspErrQ   <= (opQ == OP_RESERVED);
         rspSomeQ  <= encSome;
         rspIndexQ <= encIndex;
         rspCountQ <= countD;
         if (opQ == OP_READ) begin
            readDataQ <= orData;
         end
      end
   end

endmodule

// File: tb/tb_cam_engine.sv
// Self-checking bench for cam_engine: directed scenarios with literal
// expectations, then randomized commands, all checked each cycle against a
// behavioural model of the CAM kept in plain arrays.
module tb_cam_engine;
   import cam_pkg::*;

   localparam int NB = 8;
   localparam int NC = 8;
   localparam int IW = $clog2(NC);
   localparam int CW = $clog2(NC + 1);

   logic          CLK = 1'b0;
   logic          RST;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [NB-1:0] comparand;
   logic [NB-1:0] mask;
   logic [NB-1:0] wdata;
   logic [NB-1:0] wmask;
   logic          rsp_valid;
   logic          rsp_err;
   logic          rsp_some;
   logic [IW-1:0] rsp_index;
   logic [CW-1:0] rsp_count;
   logic [NB-1:0] read_data;
   logic [NC-1:0] tag_wires;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [NB-1:0] modelCells [NC];
   logic [NC-1:0] modelTags;
   int            modelPhase;
   logic [2:0]    pendOp;
   logic [NB-1:0] pendCmp;
   logic [NB-1:0] pendMask;
   logic [NB-1:0] pendWd;
   logic [NB-1:0] pendWm;
   logic          expErr;
   logic          expSome;
   logic [IW-1:0] expIndex;
   logic [CW-1:0] expCount;
   logic [NB-1:0] expRead;

   cam_engine #(
      .NUM_BITS  (NB),
      .NUM_CELLS (NC),
      .IDX_W     (IW),
      .CNT_W     (CW)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .comparand (comparand),
      .mask      (mask),
      .wdata     (wdata),
      .wmask     (wmask),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_some  (rsp_some),
      .rsp_index (rsp_index),
      .rsp_count (rsp_count),
      .read_data (read_data),
      .tag_wires (tag_wires)
   );

   // Free-running clock, 10 time units per period.
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic cellMatches(input int i);
      return ((modelCells[i] ^ pendCmp) & pendMask) == '0;
   endfunction

   // Applies one accepted command to the model cells and tags, then derives
   // the expected response from the resulting tags.
   task automatic modelExecute();
      int first;
      int cnt;
      case (pendOp)
         3'd1: for (int i = 0; i < NC; i++) modelTags[i] = cellMatches(i);
         3'd2: for (int i = 0; i < NC; i++) modelTags[i] = modelTags[i] & cellMatches(i);
         3'd3: modelTags = '1;
         3'd4: begin
            first = -1;
            for (int i = 0; i < NC; i++) if (modelTags[i] && first < 0) first = i;
            modelTags = '0;
            if (first >= 0) modelTags[first] = 1'b1;
         end
         3'd5: begin
            for (int i = 0; i < NC; i++)
               if (modelTags[i]) modelCells[i] = (modelCells[i] & ~pendWm) | (pendWd & pendWm);
         end
         3'd6: begin
            expRead = '0;
            for (int i = 0; i < NC; i++) if (modelTags[i]) expRead = expRead | modelCells[i];
         end
         default: ;
      endcase
      expErr = (pendOp == 3'd7);
      cnt    = 0;
      first  = -1;
      for (int i = 0; i < NC; i++) begin
         if (modelTags[i]) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      expCount = CW'(cnt);
      expSome  = (cnt > 0);
      expIndex = (first < 0) ? '0 : IW'(first);
   endtask

   // Model timeline plus the per-cycle comparison: each rising edge advances
   // the model (accept, commit, report), each falling edge compares every
   // DUT output against it.
   initial begin
      modelPhase = 0;
      forever begin
         @(posedge CLK);
         if (RST) begin
            for (int i = 0; i < NC; i++) modelCells[i] = '0;
            modelTags  = '0;
            modelPhase = 0;
            expErr     = 1'b0;
            expSome    = 1'b0;
            expIndex   = '0;
            expCount   = '0;
            expRead    = '0;
         end else if (modelPhase == 0) begin
            if (cmd_valid) begin
               pendOp     = cmd_op;
               pendCmp    = comparand;
               pendMask   = mask;
               pendWd     = wdata;
               pendWm     = wmask;
               modelPhase = 1;
            end
         end else if (modelPhase == 1) begin
            modelExecute();
            modelPhase = 2;
         end else begin
            modelPhase = 0;
         end
         @(negedge CLK);
         checkOutput("cmd_ready",  64'(cmd_ready), 64'(modelPhase == 0));
         checkOutput("rsp_valid",  64'(rsp_valid), 64'(modelPhase == 2));
         checkOutput("tag_wires",  64'(tag_wires), 64'(modelTags));
         checkOutput("rsp_err",    64'(rsp_err),   64'(expErr));
         checkOutput("rsp_some",   64'(rsp_some),  64'(expSome));
         checkOutput("rsp_index",  64'(rsp_index), 64'(expIndex));
         checkOutput("rsp_count",  64'(rsp_count), 64'(expCount));
         checkOutput("read_data",  64'(read_data), 64'(expRead));
      end
   end

   // Issues one command from a falling edge and returns at the falling edge
   // inside its response cycle. Inputs are scrambled after the handshake to
   // show they are ignored while the command executes.
   task automatic applyStimulus(input logic [2:0] op, input logic [NB-1:0] cmp,
                                input logic [NB-1:0] msk, input logic [NB-1:0] wd,
                                input logic [NB-1:0] wm);
      int waited = 0;
      while (!cmd_ready && waited < 10) begin
         @(negedge CLK);
         waited++;
      end
      checkOutput("readyBeforeCmd", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b1;
      cmd_op    = op;
      comparand = cmp;
      mask      = msk;
      wdata     = wd;
      wmask     = wm;
      @(posedge CLK);
      @(negedge CLK);
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom_range(0, 7));
      comparand = NB'($urandom());
      mask      = NB'($urandom());
      wdata     = NB'($urandom());
      wmask     = NB'($urandom());
      checkOutput("rspValidInExec", 64'(rsp_valid), 64'(0));
      @(negedge CLK);
      checkOutput("rspValidAfter2", 64'(rsp_valid), 64'(1));
   endtask

   // Safety net so the run always ends even if the handshake wedges.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios with hand-computed expectations, then random traffic.
   initial begin
      int pulses;
      RST       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      comparand = '0;
      mask      = '0;
      wdata     = '0;
      wmask     = '0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      checkOutput("resetReady",   64'(cmd_ready), 64'(1));
      checkOutput("resetValid",   64'(rsp_valid), 64'(0));
      checkOutput("resetTags",    64'(tag_wires), 64'(0));
      checkOutput("resetCount",   64'(rsp_count), 64'(0));
      checkOutput("resetRead",    64'(read_data), 64'(0));

      applyStimulus(OP_SET_ALL, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("setAllSome",   64'(rsp_some),  64'(1));
      checkOutput("setAllIndex",  64'(rsp_index), 64'(0));
      checkOutput("setAllCount",  64'(rsp_count), 64'(8));
      checkOutput("setAllTags",   64'(tag_wires), 64'(8'hFF));

      applyStimulus(OP_WRITE, 8'h00, 8'h00, 8'hA5, 8'hFF);
      applyStimulus(OP_SEARCH, 8'hA5, 8'hFF, 8'h00, 8'h00);
      checkOutput("searchA5Count", 64'(rsp_count), 64'(8));
      applyStimulus(OP_SEARCH, 8'h5A, 8'hFF, 8'h00, 8'h00);
      checkOutput("search5aSome",  64'(rsp_some),  64'(0));
      checkOutput("search5aIndex", 64'(rsp_index), 64'(0));
      checkOutput("search5aCount", 64'(rsp_count), 64'(0));
      applyStimulus(OP_SEARCH, 8'h5A, 8'h00, 8'h00, 8'h00);
      checkOutput("maskZeroCount", 64'(rsp_count), 64'(8));

      applyStimulus(OP_WRITE, 8'h00, 8'h00, 8'h00, 8'hFF);
      for (int k = 0; k < NC; k++) begin
         applyStimulus(OP_SEARCH, 8'h00, 8'h80, 8'h00, 8'h00);
         applyStimulus(OP_SELECT_FIRST, 8'h00, 8'h00, 8'h00, 8'h00);
         applyStimulus(OP_WRITE, 8'h00, 8'h00, 8'(8'h80 | k), 8'hFF);
      end
      applyStimulus(OP_SEARCH, 8'h83, 8'hFF, 8'h00, 8'h00);
      applyStimulus(OP_WRITE, 8'h00, 8'h00, 8'h10, 8'hFF);
      applyStimulus(OP_SEARCH, 8'h87, 8'hFF, 8'h00, 8'h00);
      applyStimulus(OP_WRITE, 8'h00, 8'h00, 8'h10, 8'hFF);
      applyStimulus(OP_SEARCH, 8'h80, 8'h80, 8'h00, 8'h00);
      applyStimulus(OP_WRITE, 8'h00, 8'h00, 8'h00, 8'hFF);

      applyStimulus(OP_SEARCH, 8'h10, 8'hFF, 8'h00, 8'h00);
      checkOutput("search10Index", 64'(rsp_index), 64'(3));
      checkOutput("search10Count", 64'(rsp_count), 64'(2));
      checkOutput("search10Tags",  64'(tag_wires), 64'(8'h88));
      applyStimulus(OP_SELECT_FIRST, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("selFirstTags",  64'(tag_wires), 64'(8'h08));
      applyStimulus(OP_WRITE, 8'h00, 8'h00, 8'h01, 8'h01);
      applyStimulus(OP_READ, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("readCell3",     64'(read_data), 64'(8'h11));
      applyStimulus(OP_SEARCH_AND, 8'h11, 8'hFF, 8'h00, 8'h00);
      checkOutput("andCount",      64'(rsp_count), 64'(1));
      checkOutput("andIndex",      64'(rsp_index), 64'(3));
      applyStimulus(OP_SEARCH, 8'h10, 8'hFF, 8'h00, 8'h00);
      checkOutput("highIndex",     64'(rsp_index), 64'(7));

      applyStimulus(OP_SET_ALL, 8'h00, 8'h00, 8'h00, 8'h00);
      applyStimulus(OP_WRITE, 8'h00, 8'h00, 8'h00, 8'hFF);
      applyStimulus(OP_SELECT_FIRST, 8'h00, 8'h00, 8'h00, 8'h00);
      applyStimulus(OP_WRITE, 8'h00, 8'h00, 8'h0F, 8'hFF);
      applyStimulus(OP_SEARCH, 8'h00, 8'hFF, 8'h00, 8'h00);
      applyStimulus(OP_SELECT_FIRST, 8'h00, 8'h00, 8'h00, 8'h00);
      applyStimulus(OP_WRITE, 8'h00, 8'h00, 8'hF0, 8'hFF);
      applyStimulus(OP_SET_ALL, 8'h00, 8'h00, 8'h00, 8'h00);
      applyStimulus(OP_READ, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("readOr",        64'(read_data), 64'(8'hFF));
      applyStimulus(OP_SEARCH, 8'h55, 8'hFF, 8'h00, 8'h00);
      applyStimulus(OP_READ, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("readNone",      64'(read_data), 64'(8'h00));

      applyStimulus(OP_SET_ALL, 8'h00, 8'h00, 8'h00, 8'h00);
      applyStimulus(3'd7, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("reservedErr",   64'(rsp_err),   64'(1));
      checkOutput("reservedTags",  64'(tag_wires), 64'(8'hFF));
      applyStimulus(OP_NOP, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("nopErr",        64'(rsp_err),   64'(0));

      @(negedge CLK);
      pulses    = 0;
      cmd_valid = 1'b1;
      cmd_op    = OP_NOP;
      repeat (9) begin
         @(negedge CLK);
         if (rsp_valid) pulses++;
      end
      cmd_valid = 1'b0;
      checkOutput("heldValidPulses", 64'(pulses), 64'(3));

      applyStimulus(OP_WRITE, 8'h00, 8'h00, 8'h3C, 8'hFF);
      applyStimulus(OP_READ, 8'h00, 8'h00, 8'h00, 8'h00);
      @(negedge CLK);
      cmd_valid = 1'b1;
      cmd_op    = OP_WRITE;
      wdata     = 8'hC3;
      wmask     = 8'hFF;
      @(posedge CLK);
      @(negedge CLK);
      cmd_valid = 1'b0;
      RST       = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      checkOutput("midResetReady", 64'(cmd_ready), 64'(1));
      checkOutput("midResetTags",  64'(tag_wires), 64'(0));
      checkOutput("midResetRead",  64'(read_data), 64'(0));
      @(negedge CLK);
      checkOutput("midResetNoRsp", 64'(rsp_valid), 64'(0));

      RST       = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = OP_SET_ALL;
      @(negedge CLK);
      RST       = 1'b0;
      cmd_valid = 1'b0;
      checkOutput("rstWinsReady",  64'(cmd_ready), 64'(1));
      @(negedge CLK);
      checkOutput("rstWinsTags",   64'(tag_wires), 64'(0));
      applyStimulus(OP_SET_ALL, 8'h00, 8'h00, 8'h00, 8'h00);
      applyStimulus(OP_SEARCH, 8'h00, 8'hFF, 8'h00, 8'h00);
      checkOutput("cellsCleared",  64'(rsp_count), 64'(8));

      for (int n = 0; n < 300; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge CLK);
         applyStimulus(3'($urandom_range(0, 7)), NB'($urandom_range(0, 15)),
                       NB'($urandom()), NB'($urandom_range(0, 15)), NB'($urandom()));
      end

      repeat (3) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
